// File: rtl/flasher_sequencer_if.sv
// Purpose : host/flasher-facing signal bundle of the flasher sequencer.
// Latency : n/a (wiring only).
// Backpressure: none; start is a level request sampled only while the sequencer is idle.
//
// Build option: FLASHER_SEQ_KICKBACK_EN adds the kick_en input.
// Signals (slave = sequencer side):
//   start, repeat_n, abort, leds_in, [kick_en]        -> into the sequencer
//   flick_out, flasher_rst_n, busy, done,
//   err_timeout, runs_done                            <- out of the sequencer
interface flasher_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic [CNT_W-1:0] repeat_n;
   logic             abort;
   logic [15:0]      leds_in;
`ifdef FLASHER_SEQ_KICKBACK_EN
   logic             kick_en;
`endif
   logic             flick_out;
   logic             flasher_rst_n;
   logic             busy;
   logic             done;
   logic             err_timeout;
   logic [CNT_W-1:0] runs_done;

`ifdef FLASHER_SEQ_KICKBACK_EN
   modport master (
      output start, repeat_n, abort, leds_in, kick_en,
      input  flick_out, flasher_rst_n, busy, done, err_timeout, runs_done
   );
   modport slave (
      input  start, repeat_n, abort, leds_in, kick_en,
      output flick_out, flasher_rst_n, busy, done, err_timeout, runs_done
   );
`else
   modport master (
      output start, repeat_n, abort, leds_in,
      input  flick_out, flasher_rst_n, busy, done, err_timeout, runs_done
   );
   modport slave (
      input  start, repeat_n, abort, leds_in,
      output flick_out, flasher_rst_n, busy, done, err_timeout, runs_done
   );
`endif
endinterface

// File: rtl/flasher_sequencer.sv
// Purpose : sequences bound_flasher runs: flick pulse, wait for LEDs, run, gap, repeat N times.
// Latency : flick_out rises 1 cycle after an accepted start; all outputs registered.
// Backpressure: start ignored while busy (no queueing); abort preempts everything except IDLE.
//
// Build option: FLASHER_SEQ_KICKBACK_EN enables one extra flick per run on a leds_in[10] rise.
// Ports: clk, rst (async active-high); bus (flasher_sequencer_if.slave):
//   start/repeat_n/abort/leds_in[/kick_en] in; flick_out, flasher_rst_n, busy, done,
//   err_timeout (sticky), runs_done out.
module flasher_sequencer #(
   parameter int PULSE_W    = 2,
   parameter int GAP_CYCLES = 4,
   parameter int TIMEOUT    = 1023,
   parameter int CNT_W      = 8
) (
   input  logic                clk,
   input  logic                rst,
   flasher_sequencer_if.slave  bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PULSE  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_RUN    = 3'd3;
   localparam logic [2:0] S_GAP    = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ABORT  = 3'd6;

   // One small counter serves pulse width, gap length and the abort reset hold.
   localparam int CMAX = (PULSE_W > GAP_CYCLES) ? PULSE_W : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 2);
   localparam int TW   = $clog2(TIMEOUT + 1);

   logic [2:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [TW-1:0]    r_timer;
   logic [CNT_W-1:0] r_rep;
   logic [CNT_W-1:0] r_runs;
   logic             r_active;
   logic             r_flick;
   logic             r_rst_n;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

   logic             w_leds_nz;
   logic [CNT_W-1:0] w_runs_nxt;
   logic             w_timeout;

   assign w_leds_nz  = |bus.leds_in;
   assign w_runs_nxt = r_runs + CNT_W'(1);
   assign w_timeout  = (r_timer == TW'(TIMEOUT - 1));

`ifdef FLASHER_SEQ_KICKBACK_EN
   logic          r_led10_q;
   logic          r_kicked;
   logic          r_kick_act;
   logic [CW-1:0] r_kick_cnt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_timer    <= '0;
         r_rep      <= '0;
         r_runs     <= '0;
         r_active   <= 1'b0;
         r_flick    <= 1'b0;
         r_rst_n    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
`ifdef FLASHER_SEQ_KICKBACK_EN
         r_led10_q  <= 1'b0;
         r_kicked   <= 1'b0;
         r_kick_act <= 1'b0;
         r_kick_cnt <= '0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef FLASHER_SEQ_KICKBACK_EN
         r_led10_q <= bus.leds_in[10];
`endif
         if (bus.abort && (r_state != S_IDLE) && (r_state != S_ABORT)) begin
            // Abort wins over timeout, completion and everything else.
            r_state <= S_ABORT;
            r_flick <= 1'b0;
            r_rst_n <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
`ifdef FLASHER_SEQ_KICKBACK_EN
            r_kick_act <= 1'b0;
`endif
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_rst_n <= 1'b1;
                  r_flick <= 1'b0;
                  r_busy  <= 1'b0;
                  if (bus.start) begin
                     r_rep    <= bus.repeat_n;
                     r_runs   <= '0;
                     r_err    <= 1'b0;
                     r_busy   <= 1'b1;
                     r_cnt    <= '0;
                     r_active <= 1'b0;
                     if (bus.repeat_n == '0) begin
                        r_state <= S_DONE;
                     end else begin
                        r_state <= S_PULSE;
                        r_flick <= 1'b1;
                     end
                  end
               end

               S_PULSE: begin
                  if (r_cnt == CW'(PULSE_W - 1)) begin
                     // LEDs may already be lit during the pulse; skip the wait then.
                     r_flick <= 1'b0;
                     r_timer <= '0;
                     r_state <= (r_active || w_leds_nz) ? S_RUN : S_WAIT;
`ifdef FLASHER_SEQ_KICKBACK_EN
                     r_kicked   <= 1'b0;
                     r_kick_act <= 1'b0;
`endif
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                     if (w_leds_nz) r_active <= 1'b1;
                  end
               end

               S_WAIT: begin
                  if (w_timeout) begin
                     r_err   <= 1'b1;
                     r_rst_n <= 1'b0;
                     r_cnt   <= '0;
                     r_state <= S_ABORT;
                  end else if (w_leds_nz) begin
                     r_timer <= '0;
                     r_state <= S_RUN;
`ifdef FLASHER_SEQ_KICKBACK_EN
                     r_kicked   <= 1'b0;
                     r_kick_act <= 1'b0;
`endif
                  end else begin
                     r_timer <= r_timer + TW'(1);
                  end
               end

               S_RUN: begin
                  if (w_timeout) begin
                     r_err   <= 1'b1;
                     r_rst_n <= 1'b0;
                     r_flick <= 1'b0;
                     r_cnt   <= '0;
                     r_state <= S_ABORT;
`ifdef FLASHER_SEQ_KICKBACK_EN
                     r_kick_act <= 1'b0;
`endif
                  end else if (!w_leds_nz) begin
                     // Run finished; sequence ends exactly at the latched count.
                     r_runs  <= w_runs_nxt;
                     r_flick <= 1'b0;
                     r_cnt   <= '0;
                     r_state <= (w_runs_nxt == r_rep) ? S_DONE : S_GAP;
`ifdef FLASHER_SEQ_KICKBACK_EN
                     r_kick_act <= 1'b0;
`endif
                  end else begin
                     r_timer <= r_timer + TW'(1);
`ifdef FLASHER_SEQ_KICKBACK_EN
                     if (r_kick_act) begin
                        if (r_kick_cnt == CW'(PULSE_W - 1)) begin
                           r_flick    <= 1'b0;
                           r_kick_act <= 1'b0;
                        end else begin
                           r_kick_cnt <= r_kick_cnt + CW'(1);
                        end
                     end else if (bus.kick_en && !r_kicked &&
                                  bus.leds_in[10] && !r_led10_q) begin
                        // Single injection per run, armed again on the next RUN entry.
                        r_flick    <= 1'b1;
                        r_kick_act <= 1'b1;
                        r_kicked   <= 1'b1;
                        r_kick_cnt <= '0;
                     end
`endif
                  end
               end

               S_GAP: begin
                  if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                     r_cnt    <= '0;
                     r_active <= 1'b0;
                     r_flick  <= 1'b1;
                     r_state  <= S_PULSE;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end

               S_DONE: begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end

               S_ABORT: begin
                  // Hold the flasher in reset for two cycles; runs_done is left as is.
                  r_flick <= 1'b0;
                  if (r_cnt == CW'(1)) begin
                     r_rst_n <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end

               default: begin
                  r_state <= S_IDLE;
                  r_flick <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.flick_out     = r_flick;
   assign bus.flasher_rst_n = r_rst_n;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.err_timeout   = r_err;
   assign bus.runs_done     = r_runs;

endmodule

// File: doc/flasher_sequencer.md
Name: flasher_sequencer

Overview:
- Controller that sequences the bound_flasher LED datapath.
- Issues flick pulses of programmed width to start flasher runs and watches the 16-bit LED bus for run start and completion.
- Repeats the run N times with a configurable idle gap, supervises with a timeout, and drives the flasher's active-low reset for abort/error recovery.
- Sits between a host/test controller and the bound_flasher instance.

Parameters:
PULSE_W, 2, flick pulse width in clk cycles (>=1)
GAP_CYCLES, 4, idle cycles between end of one run and next flick (>=1)
TIMEOUT, 1023, max cycles in WAIT_ACTIVE or RUN before error
CNT_W, 8, width of repeat count and run counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; accepted only in IDLE
repeat_n  input  CNT_W  number of runs; sampled on accepted start
abort  input  1  terminate current sequence
leds_in  input  16  LED bus from flasher
flick_out  output  1  flick to flasher
flasher_rst_n  output  1  active-low reset to flasher
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on successful completion
err_timeout  output  1  sticky timeout flag
runs_done  output  CNT_W  completed runs in current sequence

Behaviour:
- All outputs registered.
- Reset values: flick_out=0, flasher_rst_n=0, busy=0, done=0, err_timeout=0, runs_done=0, state=IDLE. flasher_rst_n goes 1 on the first clk edge after rst falls.
- States: IDLE, PULSE, WAIT_ACTIVE, RUN, GAP, DONE, ABORT.
- IDLE: flasher_rst_n=1, flick_out=0. On start:
  - latch repeat_n
  - clear runs_done and err_timeout
  - if repeat_n==0, go to DONE; otherwise go to PULSE
  - flick_out rises the cycle after start is sampled
- PULSE: flick_out=1 for exactly PULSE_W cycles. An internal active flag sets if leds_in!=0 during the pulse. At pulse end, go to RUN if active, else WAIT_ACTIVE.
- WAIT_ACTIVE: leds_in!=0 moves to RUN.
- RUN: the first cycle leds_in==16'h0000:
  - runs_done increments
  - if the new count equals repeat_n, go to DONE; otherwise go to GAP
- Timer: restarted on entry to WAIT_ACTIVE and to RUN. Reaching TIMEOUT cycles in either state sets err_timeout and goes to ABORT.
- GAP: flick_out=0 for GAP_CYCLES cycles, then PULSE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- ABORT:
  - flick_out=0, flasher_rst_n=0 for exactly 2 cycles, busy=1, then IDLE
  - no done pulse
  - runs_done holds its value
- abort input in any state other than IDLE/ABORT goes to ABORT next cycle. Priority: abort > timeout > run completion > start. abort in IDLE is ignored.
- start while busy is ignored, with no queueing.
- runs_done never exceeds the latched repeat_n. Counter width is CNT_W, with no wrap because a sequence ends at the count.
- leds_in is sampled directly (flasher is on the same clock domain), with no synchronizer.

Optional Feature:
- Macro FLASHER_SEQ_KICKBACK_EN.
- When defined:
  - adds input kick_en (1 bit)
  - in RUN with kick_en=1, the first cycle leds_in[10] rises (0→1) in each run issues one extra flick pulse of PULSE_W cycles without leaving RUN
  - at most one injection per run
  - the completion check still applies
- When undefined: no kick_en port, and flick_out is driven only in PULSE.

Test Plan:
- rst=1 then released, idle 10 cycles → flick_out=0, busy=0, flasher_rst_n=1 from first edge after release.
- start with repeat_n=2, PULSE_W=2, GAP=4, flasher model lights LEDs 3 cycles after flick and clears 130 cycles later → two 2-cycle flick pulses, runs_done 1 then 2, single done pulse, busy falls with done.
- start with repeat_n=0 → done pulses on the 2nd cycle after start, flick_out never asserts.
- start with repeat_n=1, leds_in held 0 → err_timeout=1 after 1023 cycles in WAIT_ACTIVE, flasher_rst_n low exactly 2 cycles, no done. err_timeout stays 1 until next accepted start.
- start with repeat_n=3, abort asserted mid-RUN of run 2 in the same cycle leds_in returns 0 → ABORT taken, runs_done stays 1, no done. A start during the 2-cycle ABORT is ignored.
- FLASHER_SEQ_KICKBACK_EN defined, kick_en=1, leds_in[10] rising at cycle 50 of the run → one extra 2-cycle flick_out pulse, no second pulse if leds_in[10] toggles again, run completes normally.
